// File: rtl/moore_step_counter_pkg.sv
// Shared constants for the step counter: direction encoding and end-of-range mode.
package moore_step_counter_pkg;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam int   MODE_WRAP = 1;
  localparam int   MODE_SAT  = 0;
endpackage

// File: rtl/moore_step_counter_state_reg.sv
// State register plus the previous-step-request flop, synchronous active-low reset.
module moore_step_counter_state_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] next_state,
  input  logic             s_in,
  output logic [WIDTH-1:0] state,
  output logic             s_prev
);
  // s_prev resets high so a request held through reset is not taken as a new edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= '0;
      s_prev <= 1'b1;
    end else begin
      state  <= next_state;
      s_prev <= s_in;
    end
  end
endmodule

// File: rtl/moore_step_counter.sv
// Moore step controller: steps once per sampled rising edge of inputS, with load priority
// and wrap or saturate behaviour at the ends; outputs decode registered state only.
module moore_step_counter
  import moore_step_counter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int WRAP  = 1
) (
  input  logic             inputClk,
  input  logic             inputReset,
  input  logic             inputI,
  input  logic             inputS,
  input  logic             inputLoad,
  input  logic [WIDTH-1:0] inputData,
  output logic [WIDTH-1:0] outputB,
  output logic             outputMax,
  output logic             outputMin
);
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;
  logic             s_prev;
  logic             step;
  logic             at_max;
  logic             at_min;

  assign step   = inputS & ~s_prev;
  assign at_max = &state;
  assign at_min = ~|state;

  // Load wins over step; a step coinciding with a load is dropped.
  always_comb begin
    next_state = state;
    if (inputLoad) begin
      next_state = inputData;
    end else if (step) begin
      if (inputI == DIR_UP) begin
        if (!(at_max && WRAP == MODE_SAT))
          next_state = state + WIDTH'(1);
      end else if (inputI == DIR_DOWN) begin
        if (!(at_min && WRAP == MODE_SAT))
          next_state = state - WIDTH'(1);
      end
    end
  end

  moore_step_counter_state_reg #(.WIDTH(WIDTH)) u_state_reg (
    .clk        (inputClk),
    .rst_n      (inputReset),
    .next_state (next_state),
    .s_in       (inputS),
    .state      (state),
    .s_prev     (s_prev)
  );

  assign outputB   = state;
  assign outputMax = at_max;
  assign outputMin = at_min;
endmodule

// File: tb/tb_moore_step_counter.sv
// Directed bench: a 2-bit wrapping instance and a 4-bit saturating instance.
module tb_moore_step_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2 = 1'b0, i2 = 1'b1, s2 = 1'b0, ld2 = 1'b0;
  logic [1:0] d2 = '0, b2;
  logic       max2, min2;

  logic       rst4 = 1'b0, i4 = 1'b1, s4 = 1'b0, ld4 = 1'b0;
  logic [3:0] d4 = '0, b4;
  logic       max4, min4;

  int errors = 0;
  int checks = 0;

  moore_step_counter #(.WIDTH(2), .WRAP(1)) dut2 (
    .inputClk(clk), .inputReset(rst2), .inputI(i2), .inputS(s2),
    .inputLoad(ld2), .inputData(d2),
    .outputB(b2), .outputMax(max2), .outputMin(min2)
  );

  moore_step_counter #(.WIDTH(4), .WRAP(0)) dut4 (
    .inputClk(clk), .inputReset(rst4), .inputI(i4), .inputS(s4),
    .inputLoad(ld4), .inputData(d4),
    .outputB(b4), .outputMax(max4), .outputMin(min4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse2();
    s2 = 1'b0; tick();
    s2 = 1'b1; tick();
  endtask

  task automatic pulse4();
    s4 = 1'b0; tick();
    s4 = 1'b1; tick();
  endtask

  logic [1:0] wrap_up_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0] wrap_dn_exp [2] = '{2'd0, 2'd3};

  initial begin
    // Reset with S held high on the 2-bit instance
    rst2 = 1'b0; s2 = 1'b1; rst4 = 1'b0;
    tick();
    check("rst2_b", b2, 0);
    check("rst2_min", min2, 1);
    check("rst2_max", max2, 0);
    rst2 = 1'b1; rst4 = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("held_b", b2, 0);
    check("held_min", min2, 1);
    s2 = 1'b0; tick();
    s2 = 1'b1; tick();
    check("reedge_b", b2, 1);

    // Wrap up / down from a fresh reset
    rst2 = 1'b0; tick(); rst2 = 1'b1;
    i2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pulse2();
      check("wrap_up_b", b2, wrap_up_exp[k]);
      check("wrap_up_max", max2, (wrap_up_exp[k] == 2'd3));
    end
    i2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pulse2();
      check("wrap_dn_b", b2, wrap_dn_exp[k]);
    end
    check("wrap_dn_max", max2, 1);

    // Saturation on the 4-bit instance
    ld4 = 1'b1; d4 = 4'd14; tick(); ld4 = 1'b0;
    check("load14", b4, 14);
    i4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulse4();
      check("sat_up_b", b4, 15);
      check("sat_up_max", max4, 1);
    end
    ld4 = 1'b1; d4 = 4'd1; tick(); ld4 = 1'b0;
    check("load1", b4, 1);
    i4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse4();
      check("sat_dn_b", b4, 0);
      check("sat_dn_min", min4, 1);
    end

    // Load versus step collision
    ld4 = 1'b1; d4 = 4'd5; s4 = 1'b0; tick(); ld4 = 1'b0;
    check("load5", b4, 5);
    i4 = 1'b1; ld4 = 1'b1; d4 = 4'd9; s4 = 1'b1; tick(); ld4 = 1'b0;
    check("collide_b", b4, 9);
    tick();
    check("collide_hold", b4, 9);

    // Reset beats load and step
    ld4 = 1'b1; d4 = 4'd3; s4 = 1'b0; tick(); ld4 = 1'b0;
    check("load3", b4, 3);
    rst4 = 1'b0; ld4 = 1'b1; d4 = 4'd2; s4 = 1'b1; tick();
    rst4 = 1'b1; ld4 = 1'b0;
    check("midrst_b", b4, 0);
    check("midrst_min", min4, 1);
    check("midrst_max", max4, 0);

    // Held S with direction toggling: exactly one increment
    s4 = 1'b0; tick();
    i4 = 1'b1; s4 = 1'b1; tick();
    check("held_first", b4, 1);
    for (int k = 0; k < 7; k++) begin
      i4 = ~i4;
      tick();
    end
    check("held_once", b4, 1);
    check("held_min4", min4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/moore_step_counter.md
# moore_step_counter

Parametrised Moore-style step controller: the next generation of the two-bit `inputI`/`inputS` control FSM, generalised to a WIDTH-bit state with selectable wrap or saturate mode, parallel load and registered terminal flags. It steps once per rising edge of `inputS`, in the direction given by `inputI`. All outputs are decoded from registered state only, so they are Moore outputs. It sits between button/debounce logic and the display or actuator stage.

## Interface
- `WIDTH`, default 2: state/count width in bits, 1..16.
- `WRAP`, default 1: 1 means the count wraps around at the ends; 0 means it saturates at the ends.
- `inputClk`, input, 1: the single clock; all state updates on the rising edge.
- `inputReset`, input, 1: reset, synchronous, active-low.
- `inputI`, input, 1: step direction; 1 = up, 0 = down.
- `inputS`, input, 1: step request; only a 0→1 transition, as sampled on clock edges, causes a step.
- `inputLoad`, input, 1: parallel load strobe, level-sensitive, sampled each edge.
- `inputData`, input, WIDTH: load value.
- `outputB`, output, WIDTH: current state; `outputB[0]` corresponds to the legacy B0 and `outputB[1]` to B1.
- `outputMax`, output, 1: high when state is all-ones.
- `outputMin`, output, 1: high when state is zero.

## Operation
- Registers:
  - `state[WIDTH-1:0]`.
  - `sPrev`, the last sampled value of `inputS`.
- Step detect: `step = inputS & ~sPrev`. `sPrev <= inputS` on every non-reset edge, including load edges.
- Next-state priority, evaluated at each rising edge:
  1. `inputReset == 0` (highest).
  2. `inputLoad == 1`.
  3. `step == 1`.
  4. Otherwise hold.
- Reset: `state <= 0` and `sPrev <= 1`. Because `sPrev` resets to 1, an `inputS` held high through reset does not step; it must drop and rise again.
- Load: `state <= inputData`. Any step detected on the same edge is discarded, not deferred.
- Step up:
  - `state <= state + 1`, computed modulo 2^WIDTH.
  - At all-ones with `WRAP=1`: becomes 0.
  - At all-ones with `WRAP=0`: holds all-ones.
- Step down:
  - `state <= state - 1`, computed modulo 2^WIDTH.
  - At 0 with `WRAP=1`: becomes all-ones.
  - At 0 with `WRAP=0`: holds 0.
- `inputI` is sampled only on the edge where `step` is 1. Its value on any other cycle has no effect.
- Outputs are combinational decode of `state` only; no input reaches any output combinationally.
  - `outputB = state`.
  - `outputMax = &state`.
  - `outputMin = ~|state`.
- `WIDTH=1`: state toggles between 0 and 1 when `WRAP=1`. `outputMax` and `outputMin` are never both 1.

## Timing
- Values after the reset edge: `outputB=0`, `outputMin=1`, `outputMax=0`.
- Step latency: if `inputS` rises before edge k (with `sPrev=0`), `outputB` shows the new value after edge k. This is one cycle, with no additional pipeline.
- Load latency: one cycle; `outputB = inputData` after the edge that samples `inputLoad=1`.
- An `inputS` pulse must be high across at least one rising edge to be seen. A pulse that is high and low entirely between two edges is lost.
- An `inputS` held high for N cycles produces exactly one step.
- Reset asserted mid-count: the state clears at that edge regardless of load or step.
- Reset released with `inputS=1`: no step until `inputS` is sampled low and then high again.

## Structure
- Shared include `stepCounterDefs.vh`:
  - `DIR_UP=1'b1` and `DIR_DOWN=1'b0`.
  - Mode constants `MODE_WRAP=1` and `MODE_SAT=0`.
- Sub-module `stepStateReg`: a WIDTH-bit register plus the `sPrev` flip-flop, with synchronous active-low reset. It is the parametrised successor of the existing flip-flop stage.
- Next-state and output decode live in the top module as combinational logic.

## Test plan
- Reset and hold:
  - Stimulus: `WIDTH=2`; assert reset with `inputS=1` held; release; hold `inputS=1` for 5 cycles.
  - Response: `outputB` stays 0 and `outputMin=1`; then drop and raise `inputS` → `outputB=1`.
- Wrap up/down:
  - Stimulus: `WIDTH=2`, `WRAP=1`, `inputI=1`, apply 5 S pulses.
  - Response: `outputB` steps 1,2,3,0,1; `outputMax=1` only while at 3.
  - Then with `inputI=0`, apply 2 pulses → 0,3.
- Saturation:
  - Stimulus: `WIDTH=4`, `WRAP=0`; load 14, then 3 up pulses.
  - Response: 15,15,15 with `outputMax=1`.
  - Then load 1 and apply 3 down pulses → 0,0,0 with `outputMin=1`.
- Load versus step collision:
  - Stimulus: `WIDTH=4`, state 5; on one edge apply `inputLoad=1`, `inputData=9` and an S rising edge.
  - Response: `outputB=9`; the next cycle with `inputS` still high gives no further step, so it stays 9.
- Reset mid-operation:
  - Stimulus: state 3; on one edge apply reset with a load of 2 and an S edge.
  - Response: `outputB=0`, `outputMin=1`, `outputMax=0` after that edge.
- Held S and direction sampling:
  - Stimulus: `WIDTH=4`; toggle `inputI` every cycle while `inputS` is held high for 8 cycles from a rising edge with `inputI=1`.
  - Response: exactly one increment.
